// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter; the grant is held for the whole cyc.
// Optional stalled-slave watchdog is compiled in with `define WB_ARB_WATCHDOG_EN.
module wb_rr_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            m0_wb_cyc_i,
    input  logic            m0_wb_stb_i,
    input  logic            m0_wb_we_i,
    input  logic [DW/8-1:0] m0_wb_sel_i,
    input  logic [AW-1:0]   m0_wb_adr_i,
    input  logic [DW-1:0]   m0_wb_dat_i,
    output logic [DW-1:0]   m0_wb_dat_o,
    output logic            m0_wb_ack_o,
    output logic            m0_wb_err_o,

    input  logic            m1_wb_cyc_i,
    input  logic            m1_wb_stb_i,
    input  logic            m1_wb_we_i,
    input  logic [DW/8-1:0] m1_wb_sel_i,
    input  logic [AW-1:0]   m1_wb_adr_i,
    input  logic [DW-1:0]   m1_wb_dat_i,
    output logic [DW-1:0]   m1_wb_dat_o,
    output logic            m1_wb_ack_o,
    output logic            m1_wb_err_o,

    output logic            s_wb_cyc_o,
    output logic            s_wb_stb_o,
    output logic            s_wb_we_o,
    output logic [DW/8-1:0] s_wb_sel_o,
    output logic [AW-1:0]   s_wb_adr_o,
    output logic [DW-1:0]   s_wb_dat_o,
    input  logic [DW-1:0]   s_wb_dat_i,
    input  logic            s_wb_ack_i,

    output logic [1:0]      gnt_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    logic [1:0] state_reg, state_next;
    logic       last_gnt_reg, last_gnt_next;   // 0 = M0, 1 = M1
    logic       req0, req1;
    logic       abort;
    logic [1:0] gnt;

    assign req0 = m0_wb_cyc_i & m0_wb_stb_i;
    assign req1 = m1_wb_cyc_i & m1_wb_stb_i;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req0 && req1)
                    state_next = last_gnt_reg ? GNT0 : GNT1;
                else if (req0)
                    state_next = GNT0;
                else if (req1)
                    state_next = GNT1;
            end
            // Release and watchdog abort share one rule: hand over directly if the other side waits.
            GNT0: if (!m0_wb_cyc_i || abort) state_next = req1 ? GNT1 : IDLE;
            GNT1: if (!m1_wb_cyc_i || abort) state_next = req0 ? GNT0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        last_gnt_next = last_gnt_reg;
        if (state_next == GNT0)
            last_gnt_next = 1'b0;
        else if (state_next == GNT1)
            last_gnt_next = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

`ifdef WB_ARB_WATCHDOG_EN
    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYC);

    logic [15:0] wd_cnt_reg, wd_cnt_next;

    assign abort = ((state_reg == GNT0) || (state_reg == GNT1)) && (wd_cnt_reg == TIMEOUT_VAL);

    always_comb begin
        wd_cnt_next = wd_cnt_reg;
        if (abort || s_wb_ack_i || (state_next != state_reg))
            wd_cnt_next = '0;
        else if (s_wb_stb_o)
            wd_cnt_next = wd_cnt_reg + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            wd_cnt_reg <= '0;
        else
            wd_cnt_reg <= wd_cnt_next;
    end
`else
    logic unused_cfg;
    assign abort      = 1'b0;
    assign unused_cfg = ^TIMEOUT_CYC;
`endif

    // Request path: the slave sees only the granted master; cyc/stb are killed on abort.
    always_comb begin
        s_wb_cyc_o = 1'b0;
        s_wb_stb_o = 1'b0;
        s_wb_we_o  = 1'b0;
        s_wb_sel_o = '0;
        s_wb_adr_o = '0;
        s_wb_dat_o = '0;
        case (state_reg)
            GNT0: begin
                s_wb_cyc_o = m0_wb_cyc_i & ~abort;
                s_wb_stb_o = m0_wb_stb_i & ~abort;
                s_wb_we_o  = m0_wb_we_i;
                s_wb_sel_o = m0_wb_sel_i;
                s_wb_adr_o = m0_wb_adr_i;
                s_wb_dat_o = m0_wb_dat_i;
            end
            GNT1: begin
                s_wb_cyc_o = m1_wb_cyc_i & ~abort;
                s_wb_stb_o = m1_wb_stb_i & ~abort;
                s_wb_we_o  = m1_wb_we_i;
                s_wb_sel_o = m1_wb_sel_i;
                s_wb_adr_o = m1_wb_adr_i;
                s_wb_dat_o = m1_wb_dat_i;
            end
            default: ;
        endcase
    end

    assign gnt[0] = (state_reg == GNT0);
    assign gnt[1] = (state_reg == GNT1);
    assign gnt_o  = gnt;

    logic [1:0]    ack_vec, err_vec;
    logic [DW-1:0] rdat_vec [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            assign ack_vec[gi]  = gnt[gi] & s_wb_ack_i;
            assign err_vec[gi]  = gnt[gi] & abort;
            assign rdat_vec[gi] = gnt[gi] ? s_wb_dat_i : '0;
        end
    endgenerate

    assign m0_wb_ack_o = ack_vec[0];
    assign m0_wb_err_o = err_vec[0];
    assign m0_wb_dat_o = rdat_vec[0];
    assign m1_wb_ack_o = ack_vec[1];
    assign m1_wb_err_o = err_vec[1];
    assign m1_wb_dat_o = rdat_vec[1];

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter; the watchdog scenario follows WB_ARB_WATCHDOG_EN.
module tb_wb_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
    logic [3:0]  m0_sel = 0;
    logic [31:0] m0_adr = 0, m0_wdat = 0;
    logic [31:0] m0_rdat;
    logic        m0_ack, m0_err;
    logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
    logic [3:0]  m1_sel = 0;
    logic [31:0] m1_adr = 0, m1_wdat = 0;
    logic [31:0] m1_rdat;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic [31:0] s_rdat = 32'hCAFE_F00D;
    logic        s_ack = 0;
    logic [1:0]  gnt;

    int n_checks = 0;
    int n_errors = 0;

    wb_rr_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYC(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
        .m0_wb_sel_i(m0_sel), .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_wdat),
        .m0_wb_dat_o(m0_rdat), .m0_wb_ack_o(m0_ack), .m0_wb_err_o(m0_err),
        .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
        .m1_wb_sel_i(m1_sel), .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_wdat),
        .m1_wb_dat_o(m1_rdat), .m1_wb_ack_o(m1_ack), .m1_wb_err_o(m1_err),
        .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
        .s_wb_sel_o(s_sel), .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat),
        .s_wb_dat_i(s_rdat), .s_wb_ack_i(s_ack),
        .gnt_o(gnt)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL sim_timeout: got no finish, expected finish before 50000 ns");
        $fatal(1, "bench time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are read 4 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic m0_set(input logic cyc, input logic stb, input logic we, input logic [31:0] adr);
        m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_sel = 4'hF;
    endtask

    task automatic m1_set(input logic cyc, input logic stb, input logic we, input logic [31:0] adr);
        m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_sel = 4'hF;
    endtask

    task automatic go_idle(input string tag);
        m0_set(0, 0, 0, 0);
        m1_set(0, 0, 0, 0);
        s_ack = 0;
        step();
        step();
        look();
        check(tag, 64'(gnt), 64'h0);
    endtask

    initial begin
        // Reset with a request and a stray ack pending: everything must stay 0.
        m0_set(1, 1, 1, 32'h10);
        m0_wdat = 32'hDEAD_BEEF;
        s_ack = 1;
        step(); look();
        check("rst_gnt", 64'(gnt), 64'h0);
        check("rst_s_cyc", 64'(s_cyc), 64'h0);
        check("rst_s_adr", 64'(s_adr), 64'h0);
        check("rst_m0_ack", 64'(m0_ack), 64'h0);
        check("rst_m0_err", 64'(m0_err), 64'h0);

        // Single master write, slave acks two cycles after stb.
        step(); rst = 0; s_ack = 0; look();
        check("t1_req_cycle_gnt", 64'(gnt), 64'h0);
        check("t1_req_cycle_s_cyc", 64'(s_cyc), 64'h0);
        step(); look();
        check("t1_gnt", 64'(gnt), 64'h1);
        check("t1_s_adr", 64'(s_adr), 64'h10);
        check("t1_s_dat", 64'(s_wdat), 64'hDEAD_BEEF);
        check("t1_s_we", 64'(s_we), 64'h1);
        check("t1_s_sel", 64'(s_sel), 64'hF);
        check("t1_ack_wait", 64'(m0_ack), 64'h0);
        step(); look();
        check("t1_ack_wait2", 64'(m0_ack), 64'h0);
        step(); s_ack = 1; look();
        check("t1_m0_ack", 64'(m0_ack), 64'h1);
        check("t1_m1_ack", 64'(m1_ack), 64'h0);
        step(); s_ack = 0; m0_set(0, 0, 0, 0); look();
        check("t1_release_gnt", 64'(gnt), 64'h1);
        check("t1_release_s_cyc", 64'(s_cyc), 64'h0);
        step(); look();
        check("t1_idle_gnt", 64'(gnt), 64'h0);

        // Reset again: last grant goes back to M1 so the next tie goes to M0.
        rst = 1;
        step(); look();
        check("rst2_gnt", 64'(gnt), 64'h0);
        rst = 0;

        // Simultaneous first request: M0 first, then M1 with no idle gap.
        step(); m0_set(1, 1, 0, 32'h100); m1_set(1, 1, 0, 32'h200); look();
        check("t2_idle", 64'(gnt), 64'h0);
        step(); s_ack = 1; look();
        check("t2_gnt_m0", 64'(gnt), 64'h1);
        check("t2_s_adr_m0", 64'(s_adr), 64'h100);
        check("t2_m0_ack", 64'(m0_ack), 64'h1);
        check("t2_m0_rdat", 64'(m0_rdat), 64'hCAFE_F00D);
        check("t2_m1_ack", 64'(m1_ack), 64'h0);
        check("t2_m1_rdat", 64'(m1_rdat), 64'h0);
        step(); s_ack = 0; m0_set(0, 0, 0, 0); look();
        check("t2_drop_gnt", 64'(gnt), 64'h1);
        step(); s_ack = 1; look();
        check("t2_gnt_m1", 64'(gnt), 64'h2);
        check("t2_s_adr_m1", 64'(s_adr), 64'h200);
        check("t2_m1_ack", 64'(m1_ack), 64'h1);
        check("t2_m1_rdat", 64'(m1_rdat), 64'hCAFE_F00D);
        check("t2_m0_ack_off", 64'(m0_ack), 64'h0);
        go_idle("t2_end_idle");

        // Round-robin: both request continuously, single-beat cycles alternate.
        step(); m0_set(1, 1, 0, 32'h100); m1_set(1, 1, 0, 32'h200); look();
        check("t3_idle", 64'(gnt), 64'h0);
        for (int k = 0; k < 8; k++) begin
            logic [1:0] exp_gnt;
            exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
            step(); m0_set(1, 1, 0, 32'h100); m1_set(1, 1, 0, 32'h200); s_ack = 1; look();
            check($sformatf("t3_gnt_%0d", k), 64'(gnt), 64'(exp_gnt));
            check($sformatf("t3_ack_granted_%0d", k),
                  64'(exp_gnt[0] ? m0_ack : m1_ack), 64'h1);
            check($sformatf("t3_ack_other_%0d", k),
                  64'(exp_gnt[0] ? m1_ack : m0_ack), 64'h0);
            step(); s_ack = 0;
            if (exp_gnt[0]) m0_set(0, 0, 0, 0); else m1_set(0, 0, 0, 0);
            look();
            check($sformatf("t3_hold_%0d", k), 64'(gnt), 64'(exp_gnt));
        end
        go_idle("t3_end_idle");

        // Block cycle: M1 keeps cyc across stb gaps while M0 waits.
        step(); m1_set(1, 1, 0, 32'h400); look();
        check("t4_idle", 64'(gnt), 64'h0);
        for (int b = 0; b < 4; b++) begin
            step(); m1_set(1, 1, 0, 32'h400); m0_set(1, 1, 1, 32'h500); s_ack = 1; look();
            check($sformatf("t4_beat_gnt_%0d", b), 64'(gnt), 64'h2);
            check($sformatf("t4_beat_m1_ack_%0d", b), 64'(m1_ack), 64'h1);
            check($sformatf("t4_beat_m0_ack_%0d", b), 64'(m0_ack), 64'h0);
            step(); m1_set(1, 0, 0, 32'h400); s_ack = 0; look();
            check($sformatf("t4_gap_gnt_%0d", b), 64'(gnt), 64'h2);
            check($sformatf("t4_gap_s_stb_%0d", b), 64'(s_stb), 64'h0);
            check($sformatf("t4_gap_s_cyc_%0d", b), 64'(s_cyc), 64'h1);
        end
        step(); m1_set(0, 0, 0, 0); look();
        check("t4_release_gnt", 64'(gnt), 64'h2);
        step(); look();
        check("t4_handover_gnt", 64'(gnt), 64'h1);
        check("t4_handover_adr", 64'(s_adr), 64'h500);
        check("t4_handover_we", 64'(s_we), 64'h1);
        go_idle("t4_end_idle");

        // Reset in the middle of an M1 read while the slave acks.
        step(); m1_set(1, 1, 0, 32'h300); look();
        step(); look();
        check("t5_gnt_m1", 64'(gnt), 64'h2);
        check("t5_s_cyc", 64'(s_cyc), 64'h1);
        rst = 1; s_ack = 1;
        step(); look();
        check("t5_rst_gnt", 64'(gnt), 64'h0);
        check("t5_rst_s_cyc", 64'(s_cyc), 64'h0);
        check("t5_rst_s_stb", 64'(s_stb), 64'h0);
        check("t5_rst_m1_ack", 64'(m1_ack), 64'h0);
        check("t5_rst_m1_rdat", 64'(m1_rdat), 64'h0);
        rst = 0; s_ack = 0; m1_set(0, 0, 0, 0);
        step(); m0_set(1, 1, 0, 32'h100); m1_set(1, 1, 0, 32'h200); look();
        step(); look();
        check("t5_tie_gnt", 64'(gnt), 64'h1);
        go_idle("t5_end_idle");

        // Stalled slave: M0 read that never gets an ack.
        step(); m0_set(1, 1, 0, 32'h600); look();
`ifdef WB_ARB_WATCHDOG_EN
        for (int i = 0; i <= 8; i++) begin
            step(); look();
            check($sformatf("t6_err_%0d", i), 64'(m0_err), 64'(i == 8));
            check($sformatf("t6_s_cyc_%0d", i), 64'(s_cyc), 64'(i != 8));
            check($sformatf("t6_gnt_%0d", i), 64'(gnt), 64'h1);
            check($sformatf("t6_m1_err_%0d", i), 64'(m1_err), 64'h0);
        end
        step(); m0_set(0, 0, 0, 0); look();
        check("t6_after_gnt", 64'(gnt), 64'h0);
        check("t6_after_err", 64'(m0_err), 64'h0);
`else
        for (int i = 0; i < 12; i++) begin
            step(); look();
            check($sformatf("t6_err_%0d", i), 64'(m0_err), 64'h0);
            check($sformatf("t6_gnt_%0d", i), 64'(gnt), 64'h1);
            check($sformatf("t6_s_cyc_%0d", i), 64'(s_cyc), 64'h1);
        end
`endif
        go_idle("t6_end_idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Two-master Wishbone arbiter placed ahead of the wb_interconnect master port.
- M0 is the Caravel management Wishbone port; M1 is an internal bus master, e.g. a boot/DMA engine reading the SPI flash into SRAM.
- Round-robin grant, held for the whole cycle: the grant stays with a master for as long as its cyc stays high.
- Optional watchdog aborts transfers to slaves that never acknowledge.

Parameters:
- AW, 32, address width of masters and slave port
- DW, 32, data width
- TIMEOUT_CYC, 255, stalled-cycle limit before abort (used only with watchdog compiled in; legal 2..65535)

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- m0_wb_cyc_i  in  1  M0 cycle
- m0_wb_stb_i  in  1  M0 strobe
- m0_wb_we_i  in  1  M0 write enable
- m0_wb_sel_i  in  DW/8  M0 byte select
- m0_wb_adr_i  in  AW  M0 address
- m0_wb_dat_i  in  DW  M0 write data
- m0_wb_dat_o  out  DW  M0 read data
- m0_wb_ack_o  out  1  M0 acknowledge
- m0_wb_err_o  out  1  M0 error (watchdog abort)
- m1_wb_*  same set and widths as m0_wb_*, for M1
- s_wb_cyc_o  out  1  slave cycle
- s_wb_stb_o  out  1  slave strobe
- s_wb_we_o  out  1  slave write enable
- s_wb_sel_o  out  DW/8  slave byte select
- s_wb_adr_o  out  AW  slave address
- s_wb_dat_o  out  DW  slave write data
- s_wb_dat_i  in  DW  slave read data
- s_wb_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot current grant (bit0=M0, bit1=M1), 00 when idle

Behaviour:
- Reset:
  - rst_i sampled on clk_i: state=IDLE, last_gnt=M1, watchdog counter=0.
  - All outputs 0 from the first edge with rst_i high.
  - Reset asserted mid-transfer drops s_wb_cyc_o/stb_o at that edge. No ack or err is generated.
- FSM states: IDLE, GNT0, GNT1. The state register is the only grant storage.
- A master requests when cyc_i & stb_i are both high.
- IDLE transitions:
  - Only M0 requests -> GNT0.
  - Only M1 requests -> GNT1.
  - Both request -> grant the master that is not last_gnt. The first tie after reset goes to M0.
  - last_gnt is updated on entry to GNT0/GNT1.
- GNTx transitions:
  - Stay while mx_wb_cyc_i=1, including stb gaps inside a block cycle.
  - When mx_wb_cyc_i=0: go to the other master's GNT if it is requesting in that cycle, otherwise IDLE. The handover costs no idle cycle.
- Latency: the request is seen in cycle N; s_wb_* carry that master's signals from cycle N+1. One arbitration cycle; no added latency afterwards.
- Datapath muxing (combinational on state):
  - GNTx: s_wb_* = mx_wb_* inputs; mx_wb_dat_o = s_wb_dat_i; mx_wb_ack_o = s_wb_ack_i.
  - Non-granted master: dat_o=0, ack_o=0, err_o=0.
  - IDLE: all s_wb_* = 0.
- gnt_o = one-hot of state.
- Simultaneous events:
  - Release by the granted master while the other requests -> direct handover; the ack of the last beat has already been delivered.
  - s_wb_ack_i while IDLE is ignored.
- A master must not drop cyc mid-beat. If it does, the grant is released anyway and any late ack is discarded.

Optional Feature:
- Macro: WB_ARB_WATCHDOG_EN.
- With the macro:
  - A 16-bit counter increments each cycle with s_wb_stb_o=1 and s_wb_ack_i=0.
  - The counter clears on ack, on a state change, or on abort.
  - When the count reaches TIMEOUT_CYC, the arbiter raises mx_wb_err_o for one cycle to the granted master. In that cycle it forces s_wb_cyc_o=s_wb_stb_o=0, then moves to IDLE, with the same handover rule as a release.
  - The aborted master must drop cyc. Its re-request re-arbitrates normally.
- Without the macro: no counter is built, err outputs are tied 0, and a stalled slave holds the grant indefinitely.

Test Plan:
- Single master, no contention:
  - Stimulus: M0 writes 0xDEADBEEF to 0x0000_0010, slave acks 2 cycles after stb.
  - Required: s_wb_adr_o=0x10 one cycle after request; m0 ack seen; gnt_o 01 then 00.
- Simultaneous first request after reset:
  - Stimulus: M0 and M1 both request in the same cycle.
  - Required: M0 granted first; M1 granted the cycle M0 drops cyc, with no IDLE gap; gnt_o 01 -> 10.
- Round-robin fairness:
  - Stimulus: both masters request continuously, 4 single-beat cycles each.
  - Required: grants alternate 01,10,01,10; the non-granted master's ack stays 0 throughout.
- Block cycle hold:
  - Stimulus: M1 holds cyc for 4 beats with stb gaps while M0 requests.
  - Required: grant stays 10 until M1 cyc=0; then 01.
- Reset mid-operation:
  - Stimulus: rst_i pulsed in the middle of an M1 read.
  - Required: all outputs 0 at that edge; the next tie goes to M0.
- Watchdog (WB_ARB_WATCHDOG_EN, TIMEOUT_CYC=8):
  - Stimulus: M0 read to a slave that never acks.
  - Required: m0_wb_err_o=1 for exactly 1 cycle, 8 stalled cycles after s_wb_stb_o first rose; s_wb_cyc_o=0 that cycle; next state IDLE or GNT1.
  - Without the macro: err stays 0 and the grant is held.
